// File: rtl/axi4_lite_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WRESP   = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite bundle; "master" drives requests, "slave" drives responses.
interface axi4_lite_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      AWVALID;
  logic                      AWREADY;
  logic [2:0]                AWPROT;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic                      WVALID;
  logic                      WREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      BVALID;
  logic                      BREADY;
  logic [1:0]                BRESP;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [2:0]                ARPROT;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic                      RVALID;
  logic                      RREADY;
  logic [1:0]                RRESP;
  logic [DATA_WIDTH-1:0]     RDATA;

  modport master (
    output AWVALID, AWPROT, AWADDR, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARPROT, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA
  );

  modport slave (
    input  AWVALID, AWPROT, AWADDR, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARPROT, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA
  );
endinterface

// File: rtl/axi4_lite_arbiter_rr_arb2.sv
// Two-input round-robin pick: prio names the master favoured on a tie.
module axi4_lite_rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  // One-hot winner; a lone requester always wins
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Shares one AXI4-Lite slave between two masters, one transaction at a time.
//
//   state      | meaning
//   IDLE       | no owner, arbitrating requests
//   WR         | AW and W of winner forwarded to slave
//   WRESP      | waiting for B handshake
//   RD_ADDR    | AR of winner forwarded to slave
//   RD_DATA    | waiting for R handshake
module axi4_lite_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                iCLK,
  input  logic                iRST,
  axi4_lite_arbiter_if.slave  m0,
  axi4_lite_arbiter_if.slave  m1,
  axi4_lite_arbiter_if.master s,
  output logic [1:0]          grant,
  output logic                busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t state, state_nxt;
  logic   prio, aw_done, w_done, sel, win_aw;
  logic [1:0] req, arb_gnt;

  logic                  mx_awvalid, mx_wvalid, mx_bready, mx_arvalid, mx_rready;
  logic [2:0]            mx_awprot, mx_arprot;
  logic [ADDR_WIDTH-1:0] mx_awaddr, mx_araddr;
  logic [DATA_WIDTH-1:0] mx_wdata;
  logic [STRB_WIDTH-1:0] mx_wstrb;

  logic                  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [2:0]            s_awprot, s_arprot;
  logic [ADDR_WIDTH-1:0] s_awaddr, s_araddr;
  logic [DATA_WIDTH-1:0] s_wdata, g_rdata;
  logic [STRB_WIDTH-1:0] s_wstrb;
  logic                  g_awready, g_wready, g_bvalid, g_arready, g_rvalid;
  logic [1:0]            g_bresp, g_rresp;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign req    = {m1.AWVALID | m1.ARVALID, m0.AWVALID | m0.ARVALID};
  assign win_aw = arb_gnt[1] ? m1.AWVALID : m0.AWVALID;
  assign sel    = grant[1];
  assign busy   = (state != ST_IDLE);

  axi4_lite_rr_arb2 u_rr_arb2 (.req(req), .prio(prio), .gnt(arb_gnt));

  assign mx_awvalid = sel ? m1.AWVALID : m0.AWVALID;
  assign mx_awprot  = sel ? m1.AWPROT  : m0.AWPROT;
  assign mx_awaddr  = sel ? m1.AWADDR  : m0.AWADDR;
  assign mx_wvalid  = sel ? m1.WVALID  : m0.WVALID;
  assign mx_wdata   = sel ? m1.WDATA   : m0.WDATA;
  assign mx_wstrb   = sel ? m1.WSTRB   : m0.WSTRB;
  assign mx_bready  = sel ? m1.BREADY  : m0.BREADY;
  assign mx_arvalid = sel ? m1.ARVALID : m0.ARVALID;
  assign mx_arprot  = sel ? m1.ARPROT  : m0.ARPROT;
  assign mx_araddr  = sel ? m1.ARADDR  : m0.ARADDR;
  assign mx_rready  = sel ? m1.RREADY  : m0.RREADY;

  assign aw_hs = s_awvalid & s.AWREADY;
  assign w_hs  = s_wvalid  & s.WREADY;
  assign b_hs  = s_bready  & s.BVALID;
  assign ar_hs = s_arvalid & s.ARREADY;
  assign r_hs  = s_rready  & s.RVALID;

  // State register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Owner, fairness pointer and write-channel completion flags
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      grant   <= 2'b00;
      prio    <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (state == ST_IDLE) begin
        if (|req) grant <= arb_gnt;
      end else if (state_nxt == ST_IDLE) begin
        grant <= 2'b00;
        prio  <= ~sel;
      end
      if (state == ST_WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  // Next-state decode; a master with both AW and AR pending writes first
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (|req) state_nxt = win_aw ? ST_WR : ST_RD_ADDR;
      ST_WR:      if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = ST_WRESP;
      ST_WRESP:   if (b_hs)  state_nxt = ST_IDLE;
      ST_RD_ADDR: if (ar_hs) state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (r_hs)  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Channel routing: only the channel(s) of the current state are live
  always_comb begin
    s_awvalid = 1'b0; s_awprot = '0; s_awaddr = '0;
    s_wvalid  = 1'b0; s_wdata  = '0; s_wstrb  = '0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0; s_arprot = '0; s_araddr = '0;
    s_rready  = 1'b0;
    g_awready = 1'b0; g_wready = 1'b0;
    g_bvalid  = 1'b0; g_bresp  = '0;
    g_arready = 1'b0;
    g_rvalid  = 1'b0; g_rresp  = '0; g_rdata = '0;
    case (state)
      ST_WR: begin
        if (!aw_done) begin
          s_awvalid = mx_awvalid;
          s_awprot  = mx_awprot;
          s_awaddr  = mx_awaddr;
          g_awready = s.AWREADY;
        end
        if (!w_done) begin
          s_wvalid = mx_wvalid;
          s_wdata  = mx_wdata;
          s_wstrb  = mx_wstrb;
          g_wready = s.WREADY;
        end
      end
      ST_WRESP: begin
        s_bready = mx_bready;
        g_bvalid = s.BVALID;
        g_bresp  = s.BRESP;
      end
      ST_RD_ADDR: begin
        s_arvalid = mx_arvalid;
        s_arprot  = mx_arprot;
        s_araddr  = mx_araddr;
        g_arready = s.ARREADY;
      end
      ST_RD_DATA: begin
        s_rready = mx_rready;
        g_rvalid = s.RVALID;
        g_rresp  = s.RRESP;
        g_rdata  = s.RDATA;
      end
      default: ;
    endcase
  end

  assign s.AWVALID = s_awvalid;
  assign s.AWPROT  = s_awprot;
  assign s.AWADDR  = s_awaddr;
  assign s.WVALID  = s_wvalid;
  assign s.WDATA   = s_wdata;
  assign s.WSTRB   = s_wstrb;
  assign s.BREADY  = s_bready;
  assign s.ARVALID = s_arvalid;
  assign s.ARPROT  = s_arprot;
  assign s.ARADDR  = s_araddr;
  assign s.RREADY  = s_rready;

  assign m0.AWREADY = grant[0] & g_awready;
  assign m0.WREADY  = grant[0] & g_wready;
  assign m0.BVALID  = grant[0] & g_bvalid;
  assign m0.BRESP   = grant[0] ? g_bresp : 2'b00;
  assign m0.ARREADY = grant[0] & g_arready;
  assign m0.RVALID  = grant[0] & g_rvalid;
  assign m0.RRESP   = grant[0] ? g_rresp : 2'b00;
  assign m0.RDATA   = grant[0] ? g_rdata : '0;

  assign m1.AWREADY = grant[1] & g_awready;
  assign m1.WREADY  = grant[1] & g_wready;
  assign m1.BVALID  = grant[1] & g_bvalid;
  assign m1.BRESP   = grant[1] ? g_bresp : 2'b00;
  assign m1.ARREADY = grant[1] & g_arready;
  assign m1.RVALID  = grant[1] & g_rvalid;
  assign m1.RRESP   = grant[1] ? g_rresp : 2'b00;
  assign m1.RDATA   = grant[1] ? g_rdata : '0;

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for the two-master AXI4-Lite arbiter.
module tb_axi4_lite_arbiter;
  import axi4_lite_pkg::*;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic [1:0] grant;
  logic       busy;
  int         n_chk = 0;
  int         n_err = 0;

  axi4_lite_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
  axi4_lite_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
  axi4_lite_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

  axi4_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .m0   (m0_if),
    .m1   (m1_if),
    .s    (s_if),
    .grant(grant),
    .busy (busy)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic clr_all();
    m0_if.AWVALID = 0; m0_if.AWPROT = 0; m0_if.AWADDR = 0; m0_if.WVALID = 0;
    m0_if.WDATA = 0; m0_if.WSTRB = 0; m0_if.BREADY = 0; m0_if.ARVALID = 0;
    m0_if.ARPROT = 0; m0_if.ARADDR = 0; m0_if.RREADY = 0;
    m1_if.AWVALID = 0; m1_if.AWPROT = 0; m1_if.AWADDR = 0; m1_if.WVALID = 0;
    m1_if.WDATA = 0; m1_if.WSTRB = 0; m1_if.BREADY = 0; m1_if.ARVALID = 0;
    m1_if.ARPROT = 0; m1_if.ARADDR = 0; m1_if.RREADY = 0;
    s_if.AWREADY = 0; s_if.WREADY = 0; s_if.BVALID = 0; s_if.BRESP = 0;
    s_if.ARREADY = 0; s_if.RVALID = 0; s_if.RRESP = 0; s_if.RDATA = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, 64'(grant), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_s_awvalid"}, 64'(s_if.AWVALID), 64'h0);
    chk({tag, "_s_wvalid"}, 64'(s_if.WVALID), 64'h0);
    chk({tag, "_s_awaddr"}, 64'(s_if.AWADDR), 64'h0);
    chk({tag, "_s_arvalid"}, 64'(s_if.ARVALID), 64'h0);
    chk({tag, "_m0_awready"}, 64'(m0_if.AWREADY), 64'h0);
    chk({tag, "_m0_wready"}, 64'(m0_if.WREADY), 64'h0);
    chk({tag, "_m0_bvalid"}, 64'(m0_if.BVALID), 64'h0);
    chk({tag, "_m1_rvalid"}, 64'(m1_if.RVALID), 64'h0);
  endtask

  initial begin
    clr_all();
    iRST = 1'b0;
    s_if.AWREADY = 1; s_if.BVALID = 1; s_if.RVALID = 1; s_if.RDATA = 32'hFFFF_FFFF;
    #1;
    chk_quiet("rst");
    chk("rst_m0_rdata", 64'(m0_if.RDATA), 64'h0);
    clr_all();
    step();
    iRST = 1'b1;
    step();

    // Read tie with prio at master 0
    m0_if.ARVALID = 1; m0_if.ARADDR = 32'h20; m0_if.RREADY = 1;
    m1_if.ARVALID = 1; m1_if.ARADDR = 32'h40; m1_if.RREADY = 1;
    #1;
    chk("tie_no_comb_grant", 64'(grant), 64'h0);
    step();
    chk("tie_grant_m0", 64'(grant), 64'h1);
    chk("tie_s_arvalid", 64'(s_if.ARVALID), 64'h1);
    chk("tie_s_araddr0", 64'(s_if.ARADDR), 64'h20);
    s_if.ARREADY = 1; #1;
    chk("tie_m0_arready", 64'(m0_if.ARREADY), 64'h1);
    chk("tie_m1_arready", 64'(m1_if.ARREADY), 64'h0);
    step();
    m0_if.ARVALID = 0; s_if.ARREADY = 0;
    s_if.RVALID = 1; s_if.RDATA = 32'h11; s_if.RRESP = RESP_OKAY; #1;
    chk("tie_m0_rvalid", 64'(m0_if.RVALID), 64'h1);
    chk("tie_m0_rdata", 64'(m0_if.RDATA), 64'h11);
    chk("tie_m1_rdata_hidden", 64'(m1_if.RDATA), 64'h0);
    step();
    s_if.RVALID = 0;
    chk("tie_idle_busy", 64'(busy), 64'h0);
    step();
    chk("tie_grant_m1", 64'(grant), 64'h2);
    chk("tie_s_araddr1", 64'(s_if.ARADDR), 64'h40);
    s_if.ARREADY = 1;
    step();
    m1_if.ARVALID = 0; s_if.ARREADY = 0;
    s_if.RVALID = 1; s_if.RDATA = 32'h22; #1;
    chk("tie_m1_rdata", 64'(m1_if.RDATA), 64'h22);
    chk("tie_m0_rvalid_hidden", 64'(m0_if.RVALID), 64'h0);
    step();
    s_if.RVALID = 0;
    m0_if.ARVALID = 1; m0_if.ARADDR = 32'h24;
    m1_if.ARVALID = 1; m1_if.ARADDR = 32'h44;
    step();
    chk("tie2_grant_m0", 64'(grant), 64'h1);
    s_if.ARREADY = 1;
    step();
    m0_if.ARVALID = 0; m1_if.ARVALID = 0; s_if.ARREADY = 0;
    s_if.RVALID = 1; s_if.RDATA = 32'h77;
    step();
    s_if.RVALID = 0;
    chk("tie2_idle_grant", 64'(grant), 64'h0);

    // m0 write, BRESP OKAY; prio now favours m1
    m0_if.AWVALID = 1; m0_if.AWADDR = 32'h1000; m0_if.WVALID = 1;
    m0_if.WDATA = 32'hDEAD_BEEF; m0_if.WSTRB = 4'hF; m0_if.BREADY = 1;
    #1;
    chk("w0_lat_awvalid", 64'(s_if.AWVALID), 64'h0);
    step();
    chk("w0_s_awvalid", 64'(s_if.AWVALID), 64'h1);
    chk("w0_s_awaddr", 64'(s_if.AWADDR), 64'h1000);
    chk("w0_s_wdata", 64'(s_if.WDATA), 64'hDEAD_BEEF);
    chk("w0_s_wstrb", 64'(s_if.WSTRB), 64'hF);
    chk("w0_grant", 64'(grant), 64'h1);
    chk("w0_busy", 64'(busy), 64'h1);
    s_if.AWREADY = 1; s_if.WREADY = 1; #1;
    chk("w0_m0_awready", 64'(m0_if.AWREADY), 64'h1);
    chk("w0_m1_awready", 64'(m1_if.AWREADY), 64'h0);
    step();
    m0_if.AWVALID = 0; m0_if.WVALID = 0; s_if.AWREADY = 0; s_if.WREADY = 0;
    s_if.BVALID = 1; s_if.BRESP = RESP_OKAY; #1;
    chk("w0_m0_bvalid", 64'(m0_if.BVALID), 64'h1);
    chk("w0_m0_bresp", 64'(m0_if.BRESP), 64'(RESP_OKAY));
    chk("w0_s_bready", 64'(s_if.BREADY), 64'h1);
    chk("w0_grant_b", 64'(grant), 64'h1);
    step();
    s_if.BVALID = 0;
    chk("w0_idle_busy", 64'(busy), 64'h0);

    // m1 write (W before AW, SLVERR) beats m0 read on prio
    m1_if.AWVALID = 1; m1_if.AWADDR = 32'h2000; m1_if.WVALID = 1;
    m1_if.WDATA = 32'hCAFE_F00D; m1_if.WSTRB = 4'h3; m1_if.BREADY = 1;
    m0_if.ARVALID = 1; m0_if.ARADDR = 32'h30; m0_if.RREADY = 1;
    step();
    chk("w1_grant", 64'(grant), 64'h2);
    chk("w1_s_awaddr", 64'(s_if.AWADDR), 64'h2000);
    chk("w1_s_wstrb", 64'(s_if.WSTRB), 64'h3);
    chk("w1_s_arvalid", 64'(s_if.ARVALID), 64'h0);
    s_if.WREADY = 1; #1;
    chk("w1_m1_wready", 64'(m1_if.WREADY), 64'h1);
    chk("w1_m1_awready_early", 64'(m1_if.AWREADY), 64'h0);
    chk("w1_m0_arready", 64'(m0_if.ARREADY), 64'h0);
    step();
    m1_if.WVALID = 0;
    chk("w1_s_wvalid_done", 64'(s_if.WVALID), 64'h0);
    chk("w1_m1_wready_done", 64'(m1_if.WREADY), 64'h0);
    chk("w1_s_awvalid_held", 64'(s_if.AWVALID), 64'h1);
    chk("w1_still_wr", 64'(s_if.BREADY), 64'h0);
    s_if.AWREADY = 1; #1;
    chk("w1_m1_awready", 64'(m1_if.AWREADY), 64'h1);
    step();
    m1_if.AWVALID = 0; s_if.AWREADY = 0; s_if.WREADY = 0;
    s_if.BVALID = 1; s_if.BRESP = RESP_SLVERR; #1;
    chk("w1_m1_bresp", 64'(m1_if.BRESP), 64'(RESP_SLVERR));
    chk("w1_m1_bvalid", 64'(m1_if.BVALID), 64'h1);
    chk("w1_m0_bvalid", 64'(m0_if.BVALID), 64'h0);
    step();
    s_if.BVALID = 0; s_if.BRESP = 0;
    chk("w1_idle_grant", 64'(grant), 64'h0);
    step();
    chk("w1_then_m0_grant", 64'(grant), 64'h1);
    chk("w1_then_m0_araddr", 64'(s_if.ARADDR), 64'h30);
    s_if.ARREADY = 1;
    step();
    m0_if.ARVALID = 0; s_if.ARREADY = 0;
    s_if.RVALID = 1; s_if.RDATA = 32'h33; s_if.RRESP = RESP_SLVERR; #1;
    chk("r0_m0_rdata", 64'(m0_if.RDATA), 64'h33);
    chk("r0_m0_rresp", 64'(m0_if.RRESP), 64'(RESP_SLVERR));
    step();
    s_if.RVALID = 0; s_if.RRESP = 0;

    // m0 AW and AR together: write, one idle cycle, then read
    m0_if.AWVALID = 1; m0_if.AWADDR = 32'h3000; m0_if.WVALID = 1;
    m0_if.WDATA = 32'h1234_5678; m0_if.WSTRB = 4'hF; m0_if.BREADY = 1;
    m0_if.ARVALID = 1; m0_if.ARADDR = 32'h50;
    step();
    chk("wr1st_s_awvalid", 64'(s_if.AWVALID), 64'h1);
    chk("wr1st_s_arvalid", 64'(s_if.ARVALID), 64'h0);
    s_if.AWREADY = 1; s_if.WREADY = 1;
    step();
    m0_if.AWVALID = 0; m0_if.WVALID = 0; s_if.AWREADY = 0; s_if.WREADY = 0;
    s_if.BVALID = 1;
    step();
    s_if.BVALID = 0;
    chk("wr1st_idle_busy", 64'(busy), 64'h0);
    chk("wr1st_idle_arvalid", 64'(s_if.ARVALID), 64'h0);
    step();
    chk("wr1st_rd_arvalid", 64'(s_if.ARVALID), 64'h1);
    chk("wr1st_rd_araddr", 64'(s_if.ARADDR), 64'h50);
    chk("wr1st_rd_grant", 64'(grant), 64'h1);
    s_if.ARREADY = 1;
    step();
    m0_if.ARVALID = 0; s_if.ARREADY = 0; s_if.RVALID = 1; s_if.RDATA = 32'h55;
    step();
    s_if.RVALID = 0;

    // m1 read while m0 holds AWVALID
    m1_if.ARVALID = 1; m1_if.ARADDR = 32'h60; m1_if.RREADY = 1;
    step();
    m0_if.AWVALID = 1; m0_if.AWADDR = 32'h4000; m0_if.WVALID = 1;
    m0_if.WDATA = 32'hA5A5_A5A5; m0_if.WSTRB = 4'hF;
    s_if.AWREADY = 1; #1;
    chk("hold_grant_m1", 64'(grant), 64'h2);
    chk("hold_m0_awready_a", 64'(m0_if.AWREADY), 64'h0);
    s_if.ARREADY = 1;
    step();
    m1_if.ARVALID = 0; s_if.ARREADY = 0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_m0_awready_d", 64'(m0_if.AWREADY), 64'h0);
      step();
    end
    s_if.RVALID = 1; s_if.RDATA = 32'h66; #1;
    chk("hold_m1_rdata", 64'(m1_if.RDATA), 64'h66);
    chk("hold_m0_awready_r", 64'(m0_if.AWREADY), 64'h0);
    step();
    s_if.RVALID = 0;
    chk("hold_idle_m0_awready", 64'(m0_if.AWREADY), 64'h0);
    step();
    chk("hold_next_grant_m0", 64'(grant), 64'h1);
    chk("hold_next_m0_awready", 64'(m0_if.AWREADY), 64'h1);

    // Reset mid-WR with slave AWREADY pending
    iRST = 1'b0; #1;
    chk_quiet("rst_mid");
    step();
    iRST = 1'b1;
    m0_if.AWVALID = 0; m0_if.WVALID = 0; s_if.AWREADY = 0;
    m1_if.ARVALID = 1; m1_if.ARADDR = 32'h70;
    step();
    chk("post_rst_grant_m1", 64'(grant), 64'h2);
    chk("post_rst_araddr", 64'(s_if.ARADDR), 64'h70);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
